dmem_sram_bridge: RTL and testbench

//   Memory-stage data bridge downstream of the pipelined datapath. Turns one M-stage load/store
//   (addr, size, byte sel, write data) into a single SRAM-like bus transaction (req/addr_ok/data_ok).

---
 rtl/dmem_sram_bridge_pkg.sv | 19 +
 rtl/dmem_align_chk.sv | 22 ++
 rtl/dmem_sram_bridge.sv | 155 +++++++++++++++
 tb/tb_dmem_sram_bridge.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_sram_bridge_pkg.sv
// Shared definitions for the M-stage data bridge: bus size codes, FSM states, default physical mask.
// Used by dmem_sram_bridge and, when DMEM_ADDR_CHECK_EN is defined, dmem_align_chk.
package dmem_sram_bridge_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // kseg0/kseg1 both fold onto the low 512 MB physical window
    localparam logic [31:0] PHYS_MASK_DEFAULT = 32'h1FFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } bridgeState_e;

endpackage

// File: rtl/dmem_align_chk.sv
// Combinational misalignment detect for half/word accesses.
// Only compiled when DMEM_ADDR_CHECK_EN is defined; the default build has no alignment check.
`ifdef DMEM_ADDR_CHECK_EN
module dmem_align_chk
    import dmem_sram_bridge_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addrLow,
    output logic       misaligned
);

    always_comb begin
        misaligned = 1'b0;
        case (size)
            SIZE_HALF: misaligned = addrLow[0];
            SIZE_WORD: misaligned = |addrLow;
            default:   misaligned = 1'b0;
        endcase
    end

endmodule
`endif

// File: rtl/dmem_sram_bridge.sv
// Turns one M-stage load/store into a single req/addr_ok/data_ok bus transaction, stalling until done.
// Optional macro DMEM_ADDR_CHECK_EN adds misaligned-access detection (adel_o/ades_o).
//
// state | meaning
// IDLE  | no transaction; a live M-stage access is issued straight from the inputs
// REQ   | request presented from latched fields, waiting for addr_ok
// WAIT  | address accepted, waiting for data_ok
// DONE  | one-cycle release of the pipeline; load data valid
module dmem_sram_bridge
    import dmem_sram_bridge_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] PHYS_MASK = ADDR_W'(PHYS_MASK_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_en_i,
    input  logic                mem_wr_i,
    input  logic [1:0]          mem_size_i,
    input  logic [DATA_W/8-1:0] mem_sel_i,
    input  logic [ADDR_W-1:0]   mem_addr_i,
    input  logic [DATA_W-1:0]   mem_wdata_i,
    output logic                stall_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                rvalid_o,
    output logic                data_req,
    output logic                data_wr,
    output logic [1:0]          data_size,
    output logic [ADDR_W-1:0]   data_addr,
    output logic [DATA_W-1:0]   data_wdata,
    input  logic                data_addr_ok,
    input  logic                data_data_ok,
    input  logic [DATA_W-1:0]   data_rdata,
    output logic                adel_o,
    output logic                ades_o
);

    localparam int NUM_LANES = DATA_W / 8;

    bridgeState_e      state;
    bridgeState_e      stateNext;

    logic              reqWr;
    logic [1:0]        reqSize;
    logic [ADDR_W-1:0] reqAddr;
    logic [DATA_W-1:0] reqWdata;

    logic [DATA_W-1:0] liveWdata;
    logic              misaligned;
    logic              issue;

`ifdef DMEM_ADDR_CHECK_EN
    dmem_align_chk uAlignChk (
        .size       (mem_size_i),
        .addrLow    (mem_addr_i[1:0]),
        .misaligned (misaligned)
    );
`else
    assign misaligned = 1'b0;
`endif

    assign issue = (state == IDLE) && mem_en_i && !misaligned;

    // Unselected store lanes go out as zero so the slave never sees stale bytes
    always_comb begin
        liveWdata = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (mem_wr_i && mem_sel_i[i]) begin
                liveWdata[i*8 +: 8] = mem_wdata_i[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reqWr    <= 1'b0;
            reqSize  <= 2'd0;
            reqAddr  <= '0;
            reqWdata <= '0;
        end else if (issue) begin
            reqWr    <= mem_wr_i;
            reqSize  <= mem_size_i;
            reqAddr  <= mem_addr_i & PHYS_MASK;
            reqWdata <= liveWdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_o <= '0;
        end else if (state == WAIT && data_data_ok && !reqWr) begin
            rdata_o <= data_rdata;
        end
    end

    always_comb begin
        stateNext  = state;
        data_req   = 1'b0;
        stall_o    = 1'b0;
        rvalid_o   = 1'b0;
        data_wr    = reqWr;
        data_size  = reqSize;
        data_addr  = reqAddr;
        data_wdata = reqWdata;
        adel_o     = 1'b0;
        ades_o     = 1'b0;

        case (state)
            IDLE: begin
                if (mem_en_i && misaligned) begin
                    adel_o = !mem_wr_i;
                    ades_o = mem_wr_i;
                end else if (mem_en_i) begin
                    // First request cycle is driven from the live inputs to save a cycle
                    data_req   = 1'b1;
                    stall_o    = 1'b1;
                    data_wr    = mem_wr_i;
                    data_size  = mem_size_i;
                    data_addr  = mem_addr_i & PHYS_MASK;
                    data_wdata = liveWdata;
                    stateNext  = data_addr_ok ? WAIT : REQ;
                end
            end
            REQ: begin
                data_req = 1'b1;
                stall_o  = 1'b1;
                if (data_addr_ok) begin
                    stateNext = WAIT;
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (data_data_ok) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                // mem_en_i still belongs to the finished instruction here; never re-issue it
                rvalid_o  = !reqWr;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Self-checking bench for dmem_sram_bridge: directed scenarios plus randomized transactions
// against a slave model with configurable addr_ok/data_ok delays.
module tb_dmem_sram_bridge;

    localparam logic [31:0] PHYS = 32'h1FFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en_i;
    logic        mem_wr_i;
    logic [1:0]  mem_size_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rvalid_o;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        adel_o;
    logic        ades_o;

    int checks = 0;
    int errors = 0;
    logic [31:0] lastLoad = 32'h0;

    dmem_sram_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .mem_en_i     (mem_en_i),
        .mem_wr_i     (mem_wr_i),
        .mem_size_i   (mem_size_i),
        .mem_sel_i    (mem_sel_i),
        .mem_addr_i   (mem_addr_i),
        .mem_wdata_i  (mem_wdata_i),
        .stall_o      (stall_o),
        .rdata_o      (rdata_o),
        .rvalid_o     (rvalid_o),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .adel_o       (adel_o),
        .ades_o       (ades_o)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Bus write data the slave should see: selected store lanes only, zero for loads
    function automatic logic [31:0] expBusWdata(input logic wr, input logic [3:0] sel, input logic [31:0] wd);
        logic [31:0] r;
        r = 32'h0;
        if (wr) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) r[i*8 +: 8] = wd[i*8 +: 8];
            end
        end
        return r;
    endfunction

    // One full transaction; the bench plays the slave with the given response delays
    task automatic runTxn(input string tag, input logic wr, input logic [1:0] size, input logic [3:0] sel,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rword,
                          input int addrDelay, input int dataDelay);
        int reqCnt, stallCnt, waitCnt, cyc;
        bit accepted, done;
        logic [31:0] expAddr, expWdata;
        expAddr  = addr & PHYS;
        expWdata = expBusWdata(wr, sel, wdata);
        reqCnt = 0; stallCnt = 0; waitCnt = 0; cyc = 0;
        accepted = 1'b0; done = 1'b0;

        @(negedge clk);
        mem_en_i = 1'b1; mem_wr_i = wr; mem_size_i = size; mem_sel_i = sel;
        mem_addr_i = addr; mem_wdata_i = wdata;
        data_addr_ok = 1'b0; data_data_ok = 1'b0;

        while (!done && cyc < 64) begin
            #1;
            if (data_req) begin
                reqCnt++;
                checks++;
                if (data_addr !== expAddr || data_wr !== wr || data_size !== size || data_wdata !== expWdata) begin
                    errors++;
                    $display("FAIL %s req_fields: got addr=%h wr=%b size=%0d wdata=%h, want addr=%h wr=%b size=%0d wdata=%h",
                             tag, data_addr, data_wr, data_size, data_wdata, expAddr, wr, size, expWdata);
                end
            end
            if (stall_o) stallCnt++;
            else done = 1'b1;

            data_addr_ok = 1'b0;
            data_data_ok = 1'b0;
            data_rdata   = $urandom;
            if (!done) begin
                if (data_req) begin
                    if (reqCnt - 1 == addrDelay) begin
                        data_addr_ok = 1'b1;
                        accepted = 1'b1;
                    end
                end else if (accepted) begin
                    waitCnt++;
                    if (waitCnt == dataDelay) begin
                        data_data_ok = 1'b1;
                        data_rdata   = rword;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end

        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: stall still %b after %0d cycles, want release", tag, stall_o, cyc);
        end
        checks++;
        if (reqCnt != addrDelay + 1) begin
            errors++;
            $display("FAIL %s req_cycles: got %0d, want %0d", tag, reqCnt, addrDelay + 1);
        end
        checks++;
        if (stallCnt != addrDelay + 1 + dataDelay) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d, want %0d", tag, stallCnt, addrDelay + 1 + dataDelay);
        end
        if (!wr) lastLoad = rword;
        checks++;
        if (rvalid_o !== !wr || rdata_o !== lastLoad || data_req !== 1'b0 || adel_o !== 1'b0 || ades_o !== 1'b0) begin
            errors++;
            $display("FAIL %s done_cycle: got rvalid=%b rdata=%h req=%b adel=%b ades=%b, want rvalid=%b rdata=%h req=0 adel=0 ades=0",
                     tag, rvalid_o, rdata_o, data_req, adel_o, ades_o, !wr, lastLoad);
        end
    endtask

    task automatic idleCycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_en_i = 1'b0;
            mem_wdata_i = $urandom;
            data_addr_ok = 1'b0; data_data_ok = 1'b0;
            #1;
            checks++;
            if (data_req !== 1'b0 || stall_o !== 1'b0 || rvalid_o !== 1'b0) begin
                errors++;
                $display("FAIL %s idle[%0d]: got req=%b stall=%b rvalid=%b, want 0 0 0", tag, i, data_req, stall_o, rvalid_o);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mem_en_i = 1'b0; mem_wr_i = 1'b0; mem_size_i = 2'd0; mem_sel_i = 4'h0;
        mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (data_req !== 1'b0 || stall_o !== 1'b0 || rvalid_o !== 1'b0 || rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: got req=%b stall=%b rvalid=%b rdata=%h, want 0 0 0 0", data_req, stall_o, rvalid_o, rdata_o);
        end
        rst = 1'b1;
        lastLoad = 32'h0;
    endtask

    task automatic test_load_zero_wait();
        runTxn("lw_zero_wait", 1'b0, 2'd2, 4'hF, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1);
        idleCycles("lw_zero_wait", 1);
    endtask

    task automatic test_store_delayed();
        runTxn("sb_delayed", 1'b1, 2'd0, 4'b0001, 32'hA000_0003, 32'h5A5A_5A5A, 32'h0, 3, 2);
        idleCycles("sb_delayed", 1);
    endtask

    task automatic test_back_to_back();
        runTxn("b2b_lw", 1'b0, 2'd2, 4'hF, 32'h8000_0100, 32'h0, 32'h1357_9BDF, 0, 1);
        runTxn("b2b_sw", 1'b1, 2'd2, 4'hF, 32'h8000_0104, 32'hCAFE_F00D, 32'h0, 0, 1);
        idleCycles("b2b_after", 2);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        mem_en_i = 1'b1; mem_wr_i = 1'b0; mem_size_i = 2'd2; mem_sel_i = 4'hF;
        mem_addr_i = 32'h8000_0020; mem_wdata_i = 32'h0;
        data_addr_ok = 1'b1; data_data_ok = 1'b0;
        @(negedge clk);
        data_addr_ok = 1'b0;
        #1;
        checks++;
        if (stall_o !== 1'b1 || data_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid wait_state: got stall=%b req=%b, want 1 0", stall_o, data_req);
        end
        rst = 1'b0;
        mem_en_i = 1'b0;
        #1;
        checks++;
        if (data_req !== 1'b0 || stall_o !== 1'b0 || rdata_o !== 32'h0 || rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid in_reset: got req=%b stall=%b rdata=%h rvalid=%b, want 0 0 0 0", data_req, stall_o, rdata_o, rvalid_o);
        end
        lastLoad = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        data_data_ok = 1'b1;
        data_rdata = 32'h1234_5678;
        #1;
        checks++;
        if (data_req !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid stray_ok: got req=%b stall=%b, want 0 0", data_req, stall_o);
        end
        @(negedge clk);
        data_data_ok = 1'b0;
        #1;
        checks++;
        if (rdata_o !== 32'h0 || rvalid_o !== 1'b0 || stall_o !== 1'b0 || data_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid after_stray: got rdata=%h rvalid=%b stall=%b req=%b, want 0 0 0 0", rdata_o, rvalid_o, stall_o, data_req);
        end
        runTxn("rst_mid_recover", 1'b0, 2'd2, 4'hF, 32'h8000_0040, 32'h0, 32'h0BAD_F00D, 1, 1);
        idleCycles("rst_mid_recover", 1);
    endtask

    task automatic test_misaligned();
`ifdef DMEM_ADDR_CHECK_EN
        @(negedge clk);
        mem_en_i = 1'b1; mem_wr_i = 1'b0; mem_size_i = 2'd1; mem_sel_i = 4'h0;
        mem_addr_i = 32'h0000_0001; mem_wdata_i = 32'h0;
        #1;
        checks++;
        if (adel_o !== 1'b1 || ades_o !== 1'b0 || data_req !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_lh: got adel=%b ades=%b req=%b stall=%b, want 1 0 0 0", adel_o, ades_o, data_req, stall_o);
        end
        @(negedge clk);
        mem_wr_i = 1'b1; mem_size_i = 2'd2; mem_sel_i = 4'hF; mem_addr_i = 32'h0000_0002;
        #1;
        checks++;
        if (adel_o !== 1'b0 || ades_o !== 1'b1 || data_req !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_sw: got adel=%b ades=%b req=%b stall=%b, want 0 1 0 0", adel_o, ades_o, data_req, stall_o);
        end
        idleCycles("misaligned_after", 1);
        checks++;
        if (adel_o !== 1'b0 || ades_o !== 1'b0) begin
            errors++;
            $display("FAIL misaligned_clear: got adel=%b ades=%b, want 0 0", adel_o, ades_o);
        end
`else
        runTxn("lh_unaligned", 1'b0, 2'd1, 4'h0, 32'h0000_0001, 32'h0, 32'h4444_5555, 0, 1);
        idleCycles("lh_unaligned", 1);
`endif
    endtask

    task automatic test_idle();
        idleCycles("idle10", 10);
    endtask

    task automatic test_random();
        for (int t = 0; t < 24; t++) begin
            logic        wr;
            logic [1:0]  size;
            logic [31:0] addr;
            size = 2'($urandom_range(0, 2));
            wr   = 1'($urandom_range(0, 1));
            addr = $urandom;
            if (size == 2'd1) addr[0] = 1'b0;
            if (size == 2'd2) addr[1:0] = 2'b00;
            runTxn($sformatf("rand%0d", t), wr, size, 4'($urandom), addr, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(1, 3));
            idleCycles($sformatf("rand%0d", t), $urandom_range(1, 2));
        end
    endtask

    initial begin
        test_reset();
        test_load_zero_wait();
        test_store_delayed();
        test_back_to_back();
        test_reset_mid();
        test_misaligned();
        test_idle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
